// File: rtl/risc_toy_fetch_unit.sv
// risc_toy_fetch_unit
// Instruction-fetch front end: request/grant fetch toward instruction memory,
// a DEPTH-entry prefetch FIFO toward decode, and branch/jump redirect that
// flushes the FIFO and discards responses still in flight.
module risc_toy_fetch_unit #(
    parameter int              AW       = 30,
    parameter int              DW       = 32,
    parameter int              DEPTH    = 4,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          CLK,
    input  logic          RST,
    output logic          IREQ,
    output logic [AW-1:0] IADDR,
    input  logic          IGNT,
    input  logic          IVALID,
    input  logic [DW-1:0] INSTR,
    input  logic          REDIR,
    input  logic [AW-1:0] REDIR_ADDR,
    output logic          OUT_VALID,
    output logic [DW-1:0] OUT_INSTR,
    output logic [AW-1:0] OUT_PC,
    input  logic          OUT_READY
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(DEPTH);

    logic [AW-1:0] fetch_pc;
    logic [AW-1:0] resp_pc;
    logic [CW-1:0] occ;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // FIFO storage is not reset; it is only observed when occ != 0
    logic [DW-1:0] fifo_instr [DEPTH];
    logic [AW-1:0] fifo_pc    [DEPTH];

    logic          grant;
    logic          resp;
    logic          drop;
    logic          push;
    logic          pop;
    logic          head_valid;
    logic [CW:0]   credit_used;
    logic [CW:0]   redir_drop;

    // Buffered plus in-flight entries never exceed DEPTH, so the FIFO cannot overflow
    assign credit_used = {1'b0, occ} + {1'b0, outstanding};
    // A response arriving in the redirect cycle is stale and consumes one of the drops
    assign redir_drop  = {1'b0, drop_cnt} + {1'b0, outstanding} - {{CW{1'b0}}, resp};

    assign IREQ       = !RST && !REDIR && (credit_used < DEPTH_LIM);
    assign IADDR      = fetch_pc;
    assign grant      = IREQ && IGNT;
    // A response with nothing outstanding is a protocol error and is ignored
    assign resp       = IVALID && (outstanding != '0);
    assign drop       = resp && (drop_cnt != '0);
    assign push       = resp && !drop && !REDIR;
    assign head_valid = (occ != '0);
    assign OUT_VALID  = head_valid && !REDIR && !RST;
    assign pop        = OUT_VALID && OUT_READY;
    assign OUT_INSTR  = head_valid ? fifo_instr[rd_ptr] : '0;
    assign OUT_PC     = head_valid ? fifo_pc[rd_ptr]    : '0;

    // Control state: PCs, counters and FIFO pointers; redirect outranks all but reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            occ         <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (REDIR) begin
            fetch_pc    <= REDIR_ADDR;
            resp_pc     <= REDIR_ADDR;
            occ         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= outstanding - CW'(resp);
            drop_cnt    <= redir_drop[CW-1:0];
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + AW'(1);
            end
            outstanding <= outstanding + CW'(grant) - CW'(resp);
            if (drop) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (push) begin
                resp_pc <= resp_pc + AW'(1);
                wr_ptr  <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            occ <= occ + CW'(push) - CW'(pop);
        end
    end

    // FIFO data write: tag each accepted instruction with its word address
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_instr[wr_ptr] <= INSTR;
            fifo_pc[wr_ptr]    <= resp_pc;
        end
    end

endmodule

// File: tb/tb_risc_toy_fetch_unit.sv
// tb_risc_toy_fetch_unit
// Directed bench for the fetch unit: a behavioural instruction memory with
// configurable latency answers grants; each grant queues the expected
// {PC, INSTR} which is checked when decode pops it. A second instance with
// RESET_PC near the top of the address space shares the control inputs and
// is served by its own one-cycle memory.
module tb_risc_toy_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IGNT;
    logic        IVALID;
    logic [31:0] INSTR;
    logic        REDIR;
    logic [29:0] REDIR_ADDR;
    logic        OUT_READY;
    logic        IREQ;
    logic [29:0] IADDR;
    logic        OUT_VALID;
    logic [31:0] OUT_INSTR;
    logic [29:0] OUT_PC;

    logic        w_ireq;
    logic [29:0] w_iaddr;
    logic        w_ivalid;
    logic [31:0] w_instr;
    logic        w_out_valid;
    logic [31:0] w_out_instr;
    logic [29:0] w_out_pc;

    localparam logic [29:0] W_RESET_PC = 30'h3FFF_FFFE;

    risc_toy_fetch_unit #(.AW(30), .DW(32), .DEPTH(4), .RESET_PC(30'h0)) dut (
        .CLK(CLK), .RST(RST), .IREQ(IREQ), .IADDR(IADDR), .IGNT(IGNT),
        .IVALID(IVALID), .INSTR(INSTR), .REDIR(REDIR), .REDIR_ADDR(REDIR_ADDR),
        .OUT_VALID(OUT_VALID), .OUT_INSTR(OUT_INSTR), .OUT_PC(OUT_PC),
        .OUT_READY(OUT_READY)
    );

    risc_toy_fetch_unit #(.AW(30), .DW(32), .DEPTH(4), .RESET_PC(W_RESET_PC)) dut_w (
        .CLK(CLK), .RST(RST), .IREQ(w_ireq), .IADDR(w_iaddr), .IGNT(IGNT),
        .IVALID(w_ivalid), .INSTR(w_instr), .REDIR(REDIR), .REDIR_ADDR(REDIR_ADDR),
        .OUT_VALID(w_out_valid), .OUT_INSTR(w_out_instr), .OUT_PC(w_out_pc),
        .OUT_READY(OUT_READY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        exp_q[$];
    ent_t        w_exp_q[$];
    logic [29:0] mq_addr[$];
    int          mq_due[$];
    logic [29:0] gaddr[$];
    logic [29:0] pops[$];
    logic [29:0] w_gaddr[$];
    logic [29:0] w_pops[$];

    int          cyc;
    int          lat;
    int          n_vec;
    int          n_err;
    int          n_grant;
    int          exp_drop;
    logic        w_pend;
    logic [29:0] w_paddr;
    logic        s_ireq;
    logic [29:0] s_iaddr;
    logic        s_ovalid;
    logic [29:0] hold_addr;
    logic [29:0] tmp_addr;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {a, 2'b11} ^ 32'hC3A5_0F1E;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: present memory responses, sample mid-cycle, update models
    task automatic tick();
        ent_t e;
        IVALID = 1'b0;
        INSTR  = '0;
        if (!RST && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            IVALID = 1'b1;
            INSTR  = mem_word(mq_addr[0]);
        end
        w_ivalid = !RST && w_pend;
        w_instr  = w_ivalid ? mem_word(w_paddr) : '0;
        @(negedge CLK);
        s_ireq   = IREQ;
        s_iaddr  = IADDR;
        s_ovalid = OUT_VALID;
        if (RST) begin
            chk("rst_ireq", IREQ, 0);
            chk("rst_out_valid", OUT_VALID, 0);
            mq_addr.delete();
            mq_due.delete();
            exp_q.delete();
            w_exp_q.delete();
            w_gaddr.delete();
            w_pops.delete();
            w_pend = 1'b0;
        end else begin
            if (REDIR) begin
                chk("redir_ireq", IREQ, 0);
                chk("redir_out_valid", OUT_VALID, 0);
                exp_drop = mq_addr.size() - (IVALID ? 1 : 0);
                exp_q.delete();
                w_exp_q.delete();
            end
            if (OUT_VALID && OUT_READY) begin
                pops.push_back(OUT_PC);
                if (exp_q.size() == 0) begin
                    chk("pop_unexpected", OUT_VALID, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_pc", OUT_PC, e.pc);
                    chk("pop_instr", OUT_INSTR, e.instr);
                end
            end
            if (IVALID) begin
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
            if (IREQ && IGNT) begin
                n_grant++;
                gaddr.push_back(IADDR);
                mq_addr.push_back(IADDR);
                mq_due.push_back(cyc + lat);
                e.pc    = IADDR;
                e.instr = mem_word(IADDR);
                exp_q.push_back(e);
            end
            if (w_out_valid && OUT_READY) begin
                w_pops.push_back(w_out_pc);
                if (w_exp_q.size() == 0) begin
                    chk("w_pop_unexpected", w_out_valid, 0);
                end else begin
                    e = w_exp_q.pop_front();
                    chk("w_pop_pc", w_out_pc, e.pc);
                    chk("w_pop_instr", w_out_instr, e.instr);
                end
            end
            w_pend  = w_ireq && IGNT;
            w_paddr = w_iaddr;
            if (w_pend) begin
                w_gaddr.push_back(w_iaddr);
                e.pc    = w_iaddr;
                e.instr = mem_word(w_iaddr);
                w_exp_q.push_back(e);
            end
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    initial begin
        n_vec = 0; n_err = 0; n_grant = 0; cyc = 0; lat = 1; exp_drop = 0;
        RST = 1'b1; IGNT = 1'b1; REDIR = 1'b0; REDIR_ADDR = '0; OUT_READY = 1'b1;
        IVALID = 1'b0; INSTR = '0; w_ivalid = 1'b0; w_instr = '0;
        w_pend = 1'b0; w_paddr = '0;

        // Reset, then streaming fetch with a one-cycle memory
        tick(); tick();
        RST = 1'b0;
        gaddr.delete(); pops.delete();
        tick();
        chk("t1_first_ireq", s_ireq, 1);
        chk("t1_first_iaddr", s_iaddr, 0);
        chk("t1_first_out_valid", s_ovalid, 0);
        repeat (11) tick();
        chk("t1_grants", gaddr.size(), 12);
        chk("t1_pops", pops.size(), 10);
        for (int i = 0; i < 10; i++) begin
            chk("t1_iaddr", gaddr[i], i);
            chk("t1_out_pc", pops[i], i);
        end
        // Address wrap on the second instance
        for (int i = 0; i < 4; i++) begin
            tmp_addr = W_RESET_PC + 30'(i);
            chk("t5_wrap_iaddr", w_gaddr[i], tmp_addr);
            chk("t5_wrap_out_pc", w_pops[i], tmp_addr);
        end

        // Decode stalled: credit limits grants to DEPTH
        RST = 1'b1; tick();
        RST = 1'b0; OUT_READY = 1'b0; n_grant = 0;
        repeat (10) tick();
        chk("t2_grants", n_grant, 4);
        chk("t2_ireq_full", s_ireq, 0);
        chk("t2_out_valid", s_ovalid, 1);
        OUT_READY = 1'b1;
        tick();
        chk("t2_ireq_pop_cycle", s_ireq, 0);
        OUT_READY = 1'b0; n_grant = 0;
        repeat (5) tick();
        chk("t2_one_more_grant", n_grant, 1);
        chk("t2_ireq_full_again", s_ireq, 0);
        OUT_READY = 1'b1;
        repeat (8) tick();

        // Redirect with two requests in flight on a three-cycle memory
        RST = 1'b1; tick();
        RST = 1'b0; lat = 3;
        tick(); tick();
        REDIR = 1'b1; REDIR_ADDR = 30'h100;
        tick();
        REDIR = 1'b0;
        chk("t3_drop_cnt", dut.drop_cnt, 2);
        pops.delete();
        repeat (10) tick();
        chk("t3_first_pc", pops[0], 30'h100);
        chk("t3_second_pc", pops[1], 30'h101);

        // Redirect coinciding with a response and a ready decode
        lat = 2;
        repeat (8) tick();
        REDIR = 1'b1; REDIR_ADDR = 30'h200;
        tick();
        REDIR = 1'b0;
        chk("t4_drop_cnt", dut.drop_cnt, exp_drop);
        tick();
        chk("t4_fifo_empty", s_ovalid, 0);
        pops.delete();
        repeat (10) tick();
        chk("t4_first_pc", pops[0], 30'h200);

        // Grant withheld: request held with a stable address
        lat = 1;
        repeat (4) tick();
        IGNT = 1'b0;
        tick();
        hold_addr = s_iaddr;
        chk("t6_ireq_held", s_ireq, 1);
        repeat (2) begin
            tick();
            chk("t6_ireq_held", s_ireq, 1);
            chk("t6_iaddr_stable", s_iaddr, hold_addr);
        end
        IGNT = 1'b1;
        tick(); tick();
        // Reset mid-stream
        RST = 1'b1; tick();
        RST = 1'b0;
        tick();
        chk("t6_restart_ireq", s_ireq, 1);
        chk("t6_restart_iaddr", s_iaddr, 0);
        repeat (6) tick();
        IGNT = 1'b0;
        repeat (8) tick();
        chk("end_exp_drained", exp_q.size(), 0);
        chk("end_w_exp_drained", w_exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
